// File: rtl/button_control_pkg.sv
// Shared constants and the mode-FSM state encoding for the button controller.
package button_control_pkg;

    localparam int unsigned NUM_LEDS             = 6;
    localparam int unsigned NUM_INPUTS           = NUM_LEDS + 1;
    localparam int unsigned DEBOUNCE_CNT_DEFAULT = 3;
    localparam int unsigned HOLD_CNT_DEFAULT     = 10;
    localparam int unsigned DEB_CNT_W            = 4;
    localparam int unsigned HOLD_W               = 8;

    typedef enum logic [1:0] {
        MODE_IDLE         = 2'd0,
        MODE_PRESSED      = 2'd1,
        MODE_WAIT_RELEASE = 2'd2
    } mode_state_e;

endpackage

// File: rtl/button_control_debounce_cell.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw input.
module debounce_cell
    import button_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic slow_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CNT - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 rise_q;
    logic                 fall_q;
    logic [DEB_CNT_W-1:0] cnt_q;

    // Synchronize, count differing samples, accept the new level after DEBOUNCE_CNT in a row.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    rise_q  <= sync2_q;
                    fall_q  <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + DEB_CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/button_control.sv
// LED-select toggling and maintenance-mode control driven by debounced push buttons.
module button_control
    import button_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
    parameter int unsigned HOLD_CNT     = HOLD_CNT_DEFAULT
) (
    input  logic                slow_clock,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] btn_raw,
    input  logic                mode_raw,
    output logic [NUM_LEDS-1:0] led_enable,
    output logic                mtne_mode,
    output logic                cfg_changed
);

    // The rise-registration cycle and the IDLE->PRESSED edge are the first two
    // high cycles, so the long press fires when hold_q has counted HOLD_CNT-2.
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(HOLD_CNT - 2);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CNT);

    logic [NUM_INPUTS-1:0] raw_all;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] fall;

    logic [NUM_LEDS-1:0] btn_rise;
    logic                mode_level;
    logic                mode_rise;
    logic                mode_fall;
    logic                unused_levels;

    mode_state_e         state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [NUM_LEDS-1:0] led_q;
    logic                mtne_q;
    logic [NUM_LEDS-1:0] led_prev_q;
    logic                mtne_prev_q;
    logic                cfg_q;

    assign raw_all = {mode_raw, btn_raw};

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
        debounce_cell #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_cell (
            .slow_clock(slow_clock),
            .reset     (reset),
            .raw       (raw_all[g]),
            .level     (level[g]),
            .rise      (rise[g]),
            .fall      (fall[g])
        );
    end

    assign btn_rise      = rise[NUM_LEDS-1:0];
    assign mode_level    = level[NUM_LEDS];
    assign mode_rise     = rise[NUM_LEDS];
    assign mode_fall     = fall[NUM_LEDS];
    assign unused_levels = ^{level[NUM_LEDS-1:0], fall[NUM_LEDS-1:0]};

    // Mode FSM plus LED toggling; a short-press clear overrides same-edge toggles.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            state_q <= MODE_IDLE;
            hold_q  <= '0;
            led_q   <= '0;
            mtne_q  <= 1'b0;
        end else begin
            if (!mtne_q) begin
                led_q <= led_q ^ btn_rise;
            end
            case (state_q)
                MODE_IDLE: begin
                    if (mode_rise) begin
                        state_q <= MODE_PRESSED;
                        hold_q  <= '0;
                    end
                end
                MODE_PRESSED: begin
                    if (mode_fall) begin
                        state_q <= MODE_IDLE;
                        if ((hold_q < HOLD_SAT) && !mtne_q) begin
                            led_q <= '0;
                        end
                    end else if (mode_level) begin
                        if (hold_q != HOLD_SAT) begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                        if (hold_q == HOLD_LONG) begin
                            state_q <= MODE_WAIT_RELEASE;
                            mtne_q  <= ~mtne_q;
                        end
                    end
                end
                MODE_WAIT_RELEASE: begin
                    if (mode_fall) begin
                        state_q <= MODE_IDLE;
                    end
                end
                default: begin
                    state_q <= MODE_IDLE;
                end
            endcase
        end
    end

    // One-cycle pulse on the edge after any change of the configuration outputs.
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            led_prev_q  <= '0;
            mtne_prev_q <= 1'b0;
            cfg_q       <= 1'b0;
        end else begin
            led_prev_q  <= led_q;
            mtne_prev_q <= mtne_q;
            cfg_q       <= (led_q != led_prev_q) || (mtne_q != mtne_prev_q);
        end
    end

    assign led_enable  = led_q;
    assign mtne_mode   = mtne_q;
    assign cfg_changed = cfg_q;

endmodule

// File: tb/tb_button_control.sv
// Scoreboard bench: stimulus pushes expected outputs from a history-based model, monitor compares.
module tb_button_control;
    import button_control_pkg::*;

    localparam int DEB  = 3;
    localparam int HOLD = 10;

    logic       slow_clock;
    logic       reset;
    logic [5:0] btn_raw;
    logic       mode_raw;
    logic [5:0] led_enable;
    logic       mtne_mode;
    logic       cfg_changed;

    button_control #(
        .DEBOUNCE_CNT(DEB),
        .HOLD_CNT    (HOLD)
    ) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .mode_raw   (mode_raw),
        .led_enable (led_enable),
        .mtne_mode  (mtne_mode),
        .cfg_changed(cfg_changed)
    );

    typedef struct packed {
        logic [5:0] led;
        logic       mtne;
        logic       cfg;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 0;

    // Reference model state: raw history, sample window, accepted levels, press bookkeeping.
    logic [6:0] raw_at[$];
    logic [6:0] samp_hist[$];
    logic [6:0] lvl;
    logic [6:0] pend_rise;
    logic [6:0] pend_fall;
    logic [5:0] m_led;
    logic       m_mtne;
    logic       m_last_chg;
    bit         in_press;
    bit         long_fired;
    int         press_start;
    int         edge_n = 0;

    initial slow_clock = 1'b1;
    always #5 slow_clock = ~slow_clock;

    function automatic void model_reset();
        raw_at.delete();
        samp_hist.delete();
        lvl        = '0;
        pend_rise  = '0;
        pend_fall  = '0;
        m_led      = '0;
        m_mtne     = 1'b0;
        m_last_chg = 1'b0;
        in_press   = 0;
        long_fired = 0;
        press_start = 0;
    endfunction

    // Expected outputs after the coming active edge, from the current inputs.
    function automatic void model_edge();
        logic [5:0] led_n;
        logic       mtne_n;
        logic [6:0] sample;
        logic [6:0] new_lvl;
        bit         all_diff;
        exp_t       e;
        edge_n++;
        led_n  = m_mtne ? m_led : (m_led ^ pend_rise[5:0]);
        mtne_n = m_mtne;
        if (pend_rise[6]) begin
            in_press    = 1;
            long_fired  = 0;
            press_start = edge_n - 1;
        end else if (pend_fall[6]) begin
            if (in_press && !long_fired && !m_mtne) led_n = '0;
            in_press = 0;
        end else if (in_press && !long_fired && lvl[6] && (edge_n - press_start) == HOLD) begin
            mtne_n     = ~m_mtne;
            long_fired = 1;
        end
        e.led  = led_n;
        e.mtne = mtne_n;
        e.cfg  = m_last_chg;
        exp_q.push_back(e);
        m_last_chg = (led_n != m_led) || (mtne_n != m_mtne);
        m_led      = led_n;
        m_mtne     = mtne_n;

        // A level flips once the last DEB synchronized samples all disagree with it.
        raw_at.push_back({mode_raw, btn_raw});
        if (raw_at.size() > 3) void'(raw_at.pop_front());
        sample = (raw_at.size() >= 3) ? raw_at[raw_at.size() - 3] : 7'd0;
        samp_hist.push_back(sample);
        if (samp_hist.size() > DEB) void'(samp_hist.pop_front());
        new_lvl = lvl;
        if (samp_hist.size() == DEB) begin
            for (int i = 0; i < 7; i++) begin
                all_diff = 1;
                foreach (samp_hist[j]) if (samp_hist[j][i] == lvl[i]) all_diff = 0;
                if (all_diff) new_lvl[i] = ~lvl[i];
            end
        end
        pend_rise = new_lvl & ~lvl;
        pend_fall = ~new_lvl & lvl;
        lvl       = new_lvl;
    endfunction

    task automatic drive(input logic [5:0] b, input logic m, input logic r, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge slow_clock);
            btn_raw  = b;
            mode_raw = m;
            if (!r) begin
                if (reset) begin
                    reset = 1'b0;
                    #1;
                    checks++;
                    if ({led_enable, mtne_mode, cfg_changed} !== 8'd0) begin
                        errors++;
                        $display("FAIL async_reset got led=%b mtne=%b cfg=%b want all 0",
                                 led_enable, mtne_mode, cfg_changed);
                    end
                end
                model_reset();
                exp_q.push_back('0);
            end else begin
                reset = 1'b1;
                model_edge();
            end
        end
    endtask

    // Monitor: compares DUT outputs after every active edge against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge slow_clock);
            #1;
            if (stim_done) break;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at t=%0t got led=%b", $time, led_enable);
            end else begin
                e = exp_q.pop_front();
                if ({led_enable, mtne_mode, cfg_changed} !== {e.led, e.mtne, e.cfg}) begin
                    errors++;
                    $display("FAIL outputs t=%0t got led=%b mtne=%b cfg=%b want led=%b mtne=%b cfg=%b",
                             $time, led_enable, mtne_mode, cfg_changed, e.led, e.mtne, e.cfg);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5:0] rb;
        logic       rm;
        logic       rr;
        reset    = 1'b0;
        btn_raw  = '0;
        mode_raw = 1'b0;
        model_reset();
        drive(6'b000000, 1'b0, 1'b0, 3);
        // Single button held: toggle then cfg pulse
        drive(6'b000100, 1'b0, 1'b1, 8);
        drive(6'b000000, 1'b0, 1'b1, 8);
        // Glitch shorter than the debounce window
        drive(6'b000001, 1'b0, 1'b1, 2);
        drive(6'b000000, 1'b0, 1'b1, 8);
        // Reach 101010 via a toggle-off and a three-button press
        drive(6'b000100, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 6);
        drive(6'b101010, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 6);
        // Short press clears the LEDs
        drive(6'b000000, 1'b1, 1'b1, 5);
        drive(6'b000000, 1'b0, 1'b1, 10);
        drive(6'b000011, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 6);
        // Long press enters maintenance; button then ignored
        drive(6'b000000, 1'b1, 1'b1, 20);
        drive(6'b000000, 1'b0, 1'b1, 8);
        drive(6'b000010, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 6);
        // Long press leaves maintenance, LEDs retained
        drive(6'b000000, 1'b1, 1'b1, 20);
        drive(6'b000000, 1'b0, 1'b1, 8);
        // Short-press fall coincides with btn[3] rise
        drive(6'b000000, 1'b1, 1'b1, 6);
        drive(6'b001000, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 8);
        // Reset mid-press, mode still held afterwards
        drive(6'b110000, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b0, 1'b1, 6);
        drive(6'b000000, 1'b1, 1'b1, 8);
        drive(6'b000000, 1'b1, 1'b0, 3);
        drive(6'b000000, 1'b1, 1'b1, 20);
        drive(6'b000000, 1'b0, 1'b1, 8);
        // Randomized segments
        for (int s = 0; s < 80; s++) begin
            rb = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            rm = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 25) != 0);
            drive(rb, rm, rr, rr ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 3)));
        end
        drive(6'b000000, 1'b0, 1'b1, 10);
        @(posedge slow_clock);
        #2;
        stim_done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_control.md
BUTTON_CONTROL -- requirements
Module: button_control

Interface
REQ-001 SHALL expose parameter DEBOUNCE_CNT, default 3, meaning consecutive differing synchronized samples needed to accept a level change (range 1..15).
REQ-002 SHALL expose parameter HOLD_CNT, default 10, meaning debounced mode-button high cycles that constitute a long press (range 2..255).
REQ-003 SHALL have port slow_clock, input, 1 bit: block clock.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low; the block is clocked by slow_clock.
REQ-005 SHALL have port btn_raw, input, 6 bits: raw active-high LED-select push buttons, asynchronous to slow_clock.
REQ-006 SHALL have port mode_raw, input, 1 bit: raw active-high mode push button, asynchronous.
REQ-007 SHALL have port led_enable, output, 6 bits: registered per-LED enable vector for the LED controller.
REQ-008 SHALL have port mtne_mode, output, 1 bit: registered maintenance-mode flag.
REQ-009 SHALL have port cfg_changed, output, 1 bit: registered one-cycle pulse when led_enable or mtne_mode changes.

Function
REQ-010 Each of the 7 raw inputs SHALL pass through a 2-flop synchronizer.
REQ-011 Per input: a counter SHALL increment on each edge where the synchronized sample differs from the debounced level, and SHALL clear on any edge where they match.
REQ-012 When the counter reaches DEBOUNCE_CNT, the debounced level SHALL take the sample value on that edge and the counter SHALL clear.
REQ-013 Latency: with DEBOUNCE_CNT=3, a raw level first sampled at edge 0 and held stable SHALL update the debounced level at edge 4.
REQ-014 A pulse shorter than DEBOUNCE_CNT synchronized cycles SHALL cause no debounced change.
REQ-015 A debounced rising edge on btn_raw[i] SHALL toggle led_enable[i] on the next edge (edge 5 in the REQ-013 example), only while mtne_mode=0.
REQ-016 Debounced falling edges on btn_raw SHALL have no effect.
REQ-017 A mode FSM with states IDLE, PRESSED, WAIT_RELEASE SHALL be implemented.
REQ-018 IDLE->PRESSED SHALL occur on a debounced mode rise, with hold counter cleared to 0.
REQ-019 In PRESSED, the hold counter SHALL increment each edge while debounced mode=1, saturating at HOLD_CNT.
REQ-020 PRESSED->IDLE on a debounced mode fall with hold counter <HOLD_CNT (short press) SHALL clear led_enable to 6'b0 on that edge, only if mtne_mode=0.
REQ-021 PRESSED->WAIT_RELEASE when hold counter reaches HOLD_CNT (long press) SHALL toggle mtne_mode on that edge.
REQ-022 WAIT_RELEASE->IDLE SHALL occur on a debounced mode fall, with no other effect.
REQ-023 Short-press clear and a button toggle on the same edge: clear SHALL win; led_enable=0.
REQ-024 Multiple button rises on one edge SHALL each toggle independently.
REQ-025 led_enable SHALL be retained unchanged while mtne_mode=1 and when mtne_mode returns to 0.
REQ-026 cfg_changed SHALL be 1 on the edge after any edge where led_enable or mtne_mode changed value, and 0 otherwise; a toggle that leaves the value equal SHALL NOT pulse.

Reset
REQ-027 On reset=0, asynchronously: led_enable=6'b0, mtne_mode=0, cfg_changed=0, FSM=IDLE, all synchronizer flops, debounced levels, and counters=0.
REQ-028 Reset asserted mid-press SHALL abort the press; after release of reset a still-held button SHALL be treated as a new press once debounced.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, PRESSED=2'd1, WAIT_RELEASE=2'd2), the default DEBOUNCE_CNT/HOLD_CNT, and LED count 6.
REQ-030 Synchronizer plus debounce logic SHALL be a sub-module named debounce_cell (parameter DEBOUNCE_CNT; ports slow_clock, reset, raw, level, rise, fall), instantiated 7 times.
REQ-031 Unreachable FSM encoding 2'd3 SHALL return to IDLE on the next edge.

Verification
REQ-032 btn_raw[2] high from edge 0, held 8 cycles -> led_enable=6'b000100 at edge 5, cfg_changed=1 at edge 6 only.
REQ-033 btn_raw[0] high for 2 cycles only -> led_enable stays 0, cfg_changed never pulses.
REQ-034 led_enable=6'b101010, mode_raw held 5 cycles -> led_enable=0 on release debounce, mtne_mode stays 0.
REQ-035 mode_raw held 20 cycles -> mtne_mode=1 exactly HOLD_CNT edges after debounced rise, no further change on release; btn_raw[1] press then ignored.
REQ-036 Short-press mode fall and btn_raw[3] debounced rise on the same edge -> led_enable=6'b000000.
REQ-037 reset pulsed low while in PRESSED with mode_raw held -> all outputs 0 immediately; new press is debounced after reset release.
